serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/adder_pkg.sv | 13 +
 rtl/full_adder.sv | 14 +
 rtl/serial_adder_ctrl.sv | 118 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the controller state encoding and the default width.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell.
// Pure gate logic; used as the serial datapath primitive.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller, one bit per cycle LSB first.
// Valid/ready on both sides; results held until consumed.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_co;

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised and directed bench for serial_adder_ctrl at WIDTH=8.
// Expected results come from signed/unsigned integer arithmetic.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // returns {ovf, c_out, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic s);
    int sx, sy, r, ur;
    logic cc, vv;
    logic [W-1:0] rs;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = s ? sx - sy : sx + sy;
    ur = s ? int'(x) - int'(y) : int'(x) + int'(y);
    rs = W'(ur);
    cc = s ? (x >= y) : (ur > 255);
    vv = (r > 127) || (r < -128);
    return {vv, cc, rs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, wait for completion, check result and latency.
  task automatic run_op(input string nm, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic s);
    logic [W+1:0] exp;
    int k;
    exp = model(x, y, s);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready got=%b want=1", nm, in_ready);
    end
    in_valid = 1'b1; a = x; b = y; sub = s;
    tick();
    in_valid = 1'b0; a = ~x; b = ~y; sub = ~s;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    total++;
    if (k !== W) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", nm, k, W);
    end
    total++;
    if ({ovf, c_out, sum} !== exp) begin
      bad++;
      $display("FAIL %s result got ovf=%b c=%b sum=%h want ovf=%b c=%b sum=%h",
               nm, ovf, c_out, sum, exp[W+1], exp[W], exp[W-1:0]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, sum, c_out, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset got rdy=%b vld=%b sum=%h c=%b v=%b want 1 0 00 0 0",
               in_ready, out_valid, sum, c_out, ovf);
    end
  endtask

  task automatic test_directed();
    run_op("add_3c_05", 8'h3C, 8'h05, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_op("random", W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic test_hold();
    logic [W-1:0] s0;
    logic [W+1:0] exp;
    exp = model(8'h5A, 8'h33, 1'b0);
    in_valid = 1'b1; a = 8'h5A; b = 8'h33; sub = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) tick();
    s0 = sum;
    total++;
    if ({ovf, c_out, sum} !== exp) begin
      bad++;
      $display("FAIL hold_result got sum=%h want=%h", sum, exp[W-1:0]);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2); a = 8'h01; b = 8'h01;
      tick();
      total++;
      if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, s0}) begin
        bad++;
        $display("FAIL hold cyc%0d got vld=%b rdy=%b sum=%h want 1 0 %h",
                 i, out_valid, in_ready, sum, s0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, s0}) begin
      bad++;
      $display("FAIL post_hold got rdy=%b vld=%b sum=%h want 1 0 %h",
               in_ready, out_valid, sum, s0);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL rst_mid got vld=%b rdy=%b sum=%h want 0 1 00",
               out_valid, in_ready, sum);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_quiet got vld=%b want 0", out_valid);
      end
    end
    run_op("after_rst", 8'h10, 8'h20, 1'b0);
  endtask

  task automatic test_back_to_back();
    localparam int N = 5;
    logic [W-1:0] xa [N];
    logic [W-1:0] xb [N];
    logic         xs [N];
    int acc_t[$];
    logic [W+1:0] expq[$];
    int idx, got, cyc;
    logic acc, ov;
    logic [W+1:0] r;
    for (int i = 0; i < N; i++) begin
      xa[i] = W'($urandom); xb[i] = W'($urandom); xs[i] = 1'($urandom);
      expq.push_back(model(xa[i], xb[i], xs[i]));
    end
    idx = 0; got = 0; cyc = 0;
    out_ready = 1'b1;
    while (got < N && cyc < 100) begin
      in_valid = (idx < N);
      if (idx < N) begin
        a = xa[idx]; b = xb[idx]; sub = xs[idx];
      end
      acc = in_valid && in_ready;
      ov  = out_valid && out_ready;
      r   = {ovf, c_out, sum};
      tick();
      if (acc) begin
        acc_t.push_back(cyc);
        idx++;
      end
      if (ov) begin
        total++;
        if (r !== expq[got]) begin
          bad++;
          $display("FAIL b2b_result%0d got=%h want=%h", got, r, expq[got]);
        end
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (got !== N) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=%0d", got, N);
    end
    for (int i = 1; i < acc_t.size(); i++) begin
      total++;
      if (acc_t[i] - acc_t[i-1] !== W + 2) begin
        bad++;
        $display("FAIL b2b_spacing%0d got=%0d want=%0d",
                 i, acc_t[i] - acc_t[i-1], W + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
